// File: rtl/sort_sequencer_if.sv
// Valid/ready bus bundle for sort_sequencer: producer side, consumer side and busy status.
interface sort_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  // Environment side: drives the producer and consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Sorter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sort_sequencer.sv
// Frame sorter: buffers DEPTH words, runs an odd-even transposition schedule
// through one registered compare-and-swap unit, then streams the frame out ascending.
module sort_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  sort_sequencer_if.slave  bus
);

  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  // With DEPTH=2 the odd pass is empty, so the schedule finishes after pass 0.
  localparam int unsigned LAST_RUN = (DEPTH < 3) ? 0 : DEPTH - 1;

  typedef enum logic [1:0] {LOAD, ISSUE, WB, OUT} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic [IW-1:0]    pass_q, pass_d;
  logic [IW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] cu_sm_q, cu_sm_d;
  logic [WIDTH-1:0] cu_lg_q, cu_lg_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [IW-1:0]    kp1;
  logic             in_hs, out_hs, last_pair, last_pass;

  assign kp1       = k_q + IW'(1);
  assign in_hs     = bus.in_valid & in_ready_q;
  assign out_hs    = out_valid_q & bus.out_ready;
  assign last_pair = (32'(k_q) + 32'd4) > DEPTH;
  assign last_pass = 32'(pass_q) >= LAST_RUN;

  // Next-state, schedule sequencing, array updates and registered-output values.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    pass_d   = pass_q;
    k_d      = k_q;
    mem_d    = mem_q;
    cu_sm_d  = cu_sm_q;
    cu_lg_d  = cu_lg_q;

    case (state_q)
      LOAD: begin
        if (in_hs) begin
          mem_d[wr_idx_q] = bus.in_data;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            pass_d   = '0;
            k_d      = '0;
            state_d  = ISSUE;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      ISSUE: begin
        // Compare unit: a = mem[k], b = mem[k+1]; ties keep operand order.
        if (mem_q[kp1] < mem_q[k_q]) begin
          cu_sm_d = mem_q[kp1];
          cu_lg_d = mem_q[k_q];
        end else begin
          cu_sm_d = mem_q[k_q];
          cu_lg_d = mem_q[kp1];
        end
        state_d = WB;
      end
      WB: begin
        mem_d[k_q] = cu_sm_q;
        mem_d[kp1] = cu_lg_q;
        state_d    = ISSUE;
        if (last_pair) begin
          if (last_pass) begin
            rd_idx_d = '0;
            state_d  = OUT;
          end else begin
            pass_d = pass_q + IW'(1);
            k_d    = pass_q[0] ? IW'(0) : IW'(1);
          end
        end else begin
          k_d = k_q + IW'(2);
        end
      end
      OUT: begin
        if (out_hs) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            state_d  = LOAD;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d == ISSUE) || (state_d == WB);
    out_valid_d = (state_d == OUT);
    out_data_d  = (state_d == OUT) ? mem_d[rd_idx_d] : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      pass_q      <= '0;
      k_q         <= '0;
      cu_sm_q     <= '0;
      cu_lg_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      pass_q      <= pass_d;
      k_q         <= k_d;
      cu_sm_q     <= cu_sm_d;
      cu_lg_q     <= cu_lg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  // in_ready is masked by reset so nothing is accepted while rst is low,
  // and reads 1 immediately once rst is released.
  assign bus.in_ready  = in_ready_q & rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer: a DEPTH=4 and a DEPTH=8 instance on a shared clock.
module tb_sort_sequencer;

  typedef logic [7:0] frame_t [8];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst8;
  bit   sel8;
  logic tb_in_valid, tb_out_ready;
  logic [7:0] tb_in_data;

  sort_sequencer_if #(.WIDTH(8)) if4 ();
  sort_sequencer_if #(.WIDTH(8)) if8 ();

  sort_sequencer #(.WIDTH(8), .DEPTH(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4));
  sort_sequencer #(.WIDTH(8), .DEPTH(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(if8));

  assign if4.in_valid  = !sel8 && tb_in_valid;
  assign if4.in_data   = tb_in_data;
  assign if4.out_ready = !sel8 && tb_out_ready;
  assign if8.in_valid  = sel8 && tb_in_valid;
  assign if8.in_data   = tb_in_data;
  assign if8.out_ready = sel8 && tb_out_ready;

  logic       obs_in_ready, obs_out_valid, obs_busy;
  logic [7:0] obs_out_data;
  assign obs_in_ready  = sel8 ? if8.in_ready  : if4.in_ready;
  assign obs_out_valid = sel8 ? if8.out_valid : if4.out_valid;
  assign obs_busy      = sel8 ? if8.busy      : if4.busy;
  assign obs_out_data  = sel8 ? if8.out_data  : if4.out_data;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_frame(input int n, input frame_t v, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 200) begin
      tb_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      tb_in_data  = v[i];
      if (tb_in_valid && obs_in_ready) i++;
      tick();
      guard++;
    end
    tb_in_valid = 1'b0;
    chk("load_count", i, n);
  endtask

  // Called in cycle T+1 after the last input handshake at edge T.
  task automatic wait_sort(input int c);
    int off = 1;
    int busy_cnt = 0;
    tb_out_ready = 1'b1;
    while (!obs_out_valid && off < 200) begin
      if (obs_busy === 1'b1) busy_cnt++;
      tick();
      off++;
    end
    chk("busy_cycles", busy_cnt, 2 * c);
    chk("first_valid_offset", off, 2 * c + 1);
    chk("busy_low_at_out", obs_busy, 0);
  endtask

  task automatic unload(input int n, input frame_t e, input logic [15:0] pat, input int pat_len);
    int i = 0;
    int p = 0;
    int guard = 0;
    while (i < n && guard < 100) begin
      tb_out_ready = (p < pat_len) ? pat[p] : 1'b1;
      chk("out_valid", obs_out_valid, 1);
      chk("out_data", obs_out_data, e[i]);
      chk("in_ready_in_out", obs_in_ready, 0);
      if (tb_out_ready) i++;
      p++;
      tick();
      guard++;
    end
    tb_out_ready = 1'b0;
    chk("unload_count", i, n);
    chk("in_ready_after_out", obs_in_ready, 1);
    chk("out_valid_after_out", obs_out_valid, 0);
  endtask

  initial begin
    frame_t v, e;
    int bc, guard;
    sel8 = 1'b0;
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b0;
    tb_in_data = 8'd0;
    rst4 = 1'b0;
    rst8 = 1'b0;

    // Reset held 3 cycles with a word offered.
    tb_in_valid = 1'b1;
    tb_in_data  = 8'd99;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("rst_in_ready", obs_in_ready, 0);
      chk("rst_out_valid", obs_out_valid, 0);
      chk("rst_busy", obs_busy, 0);
      chk("rst_out_data", obs_out_data, 0);
    end
    tb_in_valid = 1'b0;
    rst4 = 1'b1;
    rst8 = 1'b1;
    #1;
    chk("in_ready_release", obs_in_ready, 1);
    @(negedge clk);

    // Basic DEPTH=4.
    v = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    e = '{8'd1, 8'd3, 8'd7, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    load_frame(4, v, 1'b0);
    wait_sort(6);
    unload(4, e, 16'h0000, 0);

    // Duplicates and extremes.
    v = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    load_frame(4, v, 1'b0);
    wait_sort(6);
    unload(4, e, 16'h0000, 0);

    // Input gaps and output backpressure 0,0,1,0,1,1,1.
    v = '{8'd5, 8'd5, 8'd2, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    e = '{8'd2, 8'd5, 8'd5, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    load_frame(4, v, 1'b1);
    wait_sort(6);
    unload(4, e, 16'h0074, 7);

    // DEPTH=8: reverse order, then already sorted.
    sel8 = 1'b1;
    @(negedge clk);
    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_frame(8, v, 1'b0);
    wait_sort(28);
    unload(8, e, 16'h0000, 0);

    load_frame(8, e, 1'b0);
    wait_sort(28);
    unload(8, e, 16'h0000, 0);

    // Reset during the 10th busy cycle, then a fresh frame.
    v = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1};
    load_frame(8, v, 1'b0);
    bc = 0;
    guard = 0;
    while (bc < 10 && guard < 100) begin
      if (obs_busy === 1'b1) bc++;
      if (bc < 10) tick();
      guard++;
    end
    chk("busy_reached_10", bc, 10);
    rst8 = 1'b0;
    tick();
    chk("abort_busy", obs_busy, 0);
    chk("abort_out_valid", obs_out_valid, 0);
    chk("abort_in_ready", obs_in_ready, 0);
    chk("abort_out_data", obs_out_data, 0);
    rst8 = 1'b1;
    #1;
    chk("abort_in_ready_release", obs_in_ready, 1);
    @(negedge clk);
    v = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4};
    e = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_frame(8, v, 1'b0);
    wait_sort(28);
    unload(8, e, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
